// File: rtl/exe_ctrl_pkg.sv
// exe_ctrl_pkg: shared constants for the EX-stage pipeline controller.
// Holds the FSM state encoding, the trap cause code and the default
// register-index width used by exe_ctrl and hazard_detect.
package exe_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MDU_WAIT = 2'd1;
  localparam logic [1:0] TRAP     = 2'd2;

  localparam logic [3:0] CAUSE_INST_ADDR_MIS = 4'd0;

endpackage

// File: rtl/exe_ctrl_hazard_detect.sv
// hazard_detect: purely combinational load-use detector.
// Flags when the load sitting in EX writes a register that the valid ID
// instruction reads. Register x0 never produces a hazard.
module hazard_detect
  import exe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_rd_we_i,
  input  logic                  ex_is_load_i,
  output logic                  hazard_o
);

  logic rdIsZero;
  logic rs1Match;
  logic rs2Match;

  // Compare each used ID source against the EX load destination
  always_comb begin
    rdIsZero = (ex_rd_i == '0);
    rs1Match = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    rs2Match = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
    hazard_o = ex_is_load_i && ex_rd_we_i && !rdIsZero && id_valid_i &&
               (rs1Match || rs2Match);
  end

endmodule

// File: rtl/exe_ctrl.sv
// exe_ctrl: EX-stage pipeline controller. Decides stalls, bubbles and
// flushes for load-use hazards, taken branches/jumps, misaligned targets
// and the multi-cycle MDU, and drives the trap request interface.
// Optional macro EXE_CTRL_PERF_CNT_EN adds a stall-cycle counter
// (stall_cnt_o, stall_cnt_clr_i and the PERF_W parameter).
module exe_ctrl
  import exe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
`ifdef EXE_CTRL_PERF_CNT_EN
  ,
  parameter int PERF_W     = 32
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic                  ex_valid_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_rd_we_i,
  input  logic                  ex_is_load_i,
  input  logic                  ex_is_mdu_i,
  input  logic                  is_br_j_taken_i,
  input  logic                  e_inst_addr_mis_i,
  input  logic                  mdu_done_i,
  input  logic                  trap_ack_i,
  output logic                  stall_if_o,
  output logic                  stall_id_o,
  output logic                  stall_ex_o,
  output logic                  bubble_ex_o,
  output logic                  flush_if_id_o,
  output logic                  flush_id_ex_o,
  output logic                  mdu_start_o,
  output logic                  trap_req_o,
  output logic [3:0]            trap_cause_o,
  output logic                  busy_o
`ifdef EXE_CTRL_PERF_CNT_EN
  ,
  input  logic                  stall_cnt_clr_i,
  output logic [PERF_W-1:0]     stall_cnt_o
`endif
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [3:0] cause_q;
  logic [3:0] cause_d;
  logic       loadUseHazard;

  hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard_detect (
    .id_valid_i   (id_valid_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_uses_rs1_i(id_uses_rs1_i),
    .id_uses_rs2_i(id_uses_rs2_i),
    .ex_rd_i      (ex_rd_i),
    .ex_rd_we_i   (ex_rd_we_i),
    .ex_is_load_i (ex_is_load_i),
    .hazard_o     (loadUseHazard)
  );

  // Output decode and next-state selection; RUN resolves causes in priority order
  always_comb begin
    stall_if_o    = 1'b0;
    stall_id_o    = 1'b0;
    stall_ex_o    = 1'b0;
    bubble_ex_o   = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    mdu_start_o   = 1'b0;
    trap_req_o    = 1'b0;
    state_d       = state_q;
    cause_d       = cause_q;

    case (state_q)
      RUN: begin
        if (ex_valid_i) begin
          if (e_inst_addr_mis_i) begin
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
            state_d       = TRAP;
            cause_d       = CAUSE_INST_ADDR_MIS;
          end else if (is_br_j_taken_i) begin
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
          end else if (ex_is_mdu_i) begin
            mdu_start_o = 1'b1;
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            stall_ex_o  = 1'b1;
            state_d     = MDU_WAIT;
          end else if (loadUseHazard) begin
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            bubble_ex_o = 1'b1;
          end
        end
      end
      MDU_WAIT: begin
        if (mdu_done_i) begin
          state_d = RUN;
        end else begin
          stall_if_o = 1'b1;
          stall_id_o = 1'b1;
          stall_ex_o = 1'b1;
        end
      end
      TRAP: begin
        trap_req_o    = 1'b1;
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
        stall_if_o    = 1'b1;
        if (trap_ack_i) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign busy_o       = (state_q != RUN);
  assign trap_cause_o = cause_q;

  // State and latched trap cause; reset wins over every input
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cause_q <= CAUSE_INST_ADDR_MIS;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

`ifdef EXE_CTRL_PERF_CNT_EN
  logic [PERF_W-1:0] stallCnt_q;

  // Count cycles with the front end held; clear beats increment, wraps naturally
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stallCnt_q <= '0;
    end else if (stall_cnt_clr_i) begin
      stallCnt_q <= '0;
    end else if (stall_if_o) begin
      stallCnt_q <= stallCnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stallCnt_q;
`endif

endmodule
